// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported unified memory between the fetch
//                (IF) and data (MEM) stages. Each access runs through grant,
//                issue, fixed-latency wait and response. Per-stage stall
//                signals are provided. Data wins arbitration unless fetch has
//                waited through MAX_DSTREAK consecutive data grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,

  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,

  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int c_be_w  = DATA_W / 8;
  localparam int c_lat_w = $clog2(MEM_LAT + 1);
  localparam int c_stk_w = $clog2(MAX_DSTREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_owner_dm;
  logic [c_lat_w-1:0]    r_lat_cnt;
  logic [c_stk_w-1:0]    r_streak;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [c_be_w-1:0]     r_mem_be;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic                  r_if_valid;
  logic                  r_dm_valid;

  logic                  w_fetch_due;
  logic                  w_grant_dm;
  logic                  w_grant_if;

  // Fetch overrides data priority once the data streak has hit its limit
  assign w_fetch_due = if_req && (r_streak == c_stk_w'(MAX_DSTREAK));
  assign w_grant_dm  = dm_req && !w_fetch_due;
  assign w_grant_if  = if_req && !w_grant_dm;

  // Access sequencer: arbitration in IDLE, one issue cycle, latency count,
  // one-cycle completion pulse to the owning stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_lat_cnt   <= '0;
      r_streak    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_owner_dm  <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_be    <= dm_be;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            if (r_streak != c_stk_w'(MAX_DSTREAK)) begin
              r_streak <= r_streak + c_stk_w'(1);
            end
            r_state     <= S_ISSUE;
          end else if (w_grant_if) begin
            r_owner_dm  <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '1;
            r_mem_addr  <= if_addr;
            r_streak    <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            // Stores complete without waiting for memory latency
            r_dm_valid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_lat_cnt <= c_lat_w'(MEM_LAT);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == c_lat_w'(1)) begin
            if (r_owner_dm) begin
              r_dm_rdata <= mem_rdata;
              r_dm_valid <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - c_lat_w'(1);
          end
        end
        S_RESP: begin
          r_if_valid <= 1'b0;
          r_dm_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_valid  = r_if_valid;
  assign dm_valid  = r_dm_valid;
  assign if_stall  = if_req && !r_if_valid;
  assign dm_stall  = dm_req && !r_dm_valid;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                timing model predicts grants, issue and completion cycles;
//                a behavioural memory answers the DUT's bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int MEM_LAT     = 2;
  localparam int MAX_DSTREAK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  // second instance built with single-cycle memory latency
  logic        d1_if_req, d1_if_valid, d1_if_stall;
  logic [31:0] d1_if_addr, d1_if_rdata;
  logic        d1_dm_req, d1_dm_we, d1_dm_valid, d1_dm_stall;
  logic [3:0]  d1_dm_be;
  logic [31:0] d1_dm_addr, d1_dm_wdata, d1_dm_rdata;
  logic        d1_mem_en, d1_mem_we;
  logic [3:0]  d1_mem_be;
  logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic        d1_busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .MAX_DSTREAK(MAX_DSTREAK)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DSTREAK(MAX_DSTREAK)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(d1_if_req), .if_addr(d1_if_addr), .if_rdata(d1_if_rdata), .if_valid(d1_if_valid),
    .if_stall(d1_if_stall),
    .dm_req(d1_dm_req), .dm_we(d1_dm_we), .dm_be(d1_dm_be), .dm_addr(d1_dm_addr), .dm_wdata(d1_dm_wdata),
    .dm_rdata(d1_dm_rdata), .dm_valid(d1_dm_valid), .dm_stall(d1_dm_stall),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_be(d1_mem_be), .mem_addr(d1_mem_addr),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata), .busy(d1_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural memory seen by the DUT, and the model's own copy
  logic [31:0] tb_mem  [64];
  logic [31:0] ref_mem [64];
  int          rd_due = -100;
  int          rd_idx = 0;

  // transaction-level model state
  int          cyc = 0;
  int          m_free = 0, m_grant = -100, m_streak = 0;
  int          e_issue = -100, e_valid = -100;
  bit          e_dm, e_rd, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [31:0] exp_if_rdata = 0, exp_dm_rdata = 0;

  // requester behaviour: 0 = drop after completion, 1 = always re-request, 2 = random
  int          mode = 0;
  bit          seen_if = 0, seen_dm = 0;
  int          if_age = 0, dm_age = 0;
  int          lv_if = -1, lv_dm = -1;
  bit          log_en = 0;
  logic [5:0]  order = 0;
  int          n_log = 0;

  task automatic new_if_op();
    if_addr = 32'($urandom_range(0, 63)) << 2;
    if_age  = 0;
  endtask

  task automatic new_dm_op(input bit allow_we);
    dm_we    = allow_we ? 1'($urandom_range(0, 1)) : 1'b0;
    dm_be    = 4'($urandom_range(1, 15));
    dm_addr  = 32'($urandom_range(0, 63)) << 2;
    dm_wdata = $urandom;
    dm_age   = 0;
  endtask

  task automatic update_requesters();
    if (if_req && !seen_if) if_age++;
    if (dm_req && !seen_dm) dm_age++;
    if (if_age > 200) begin chk("if_req_timeout", 64'(if_age), 0); if_req = 0; if_age = 0; end
    if (dm_age > 200) begin chk("dm_req_timeout", 64'(dm_age), 0); dm_req = 0; dm_age = 0; end
    case (mode)
      0: begin
        if (seen_if) if_req = 0;
        if (seen_dm) dm_req = 0;
      end
      1: begin
        if (seen_if || !if_req) begin if_req = 1; new_if_op(); end
        if (seen_dm || !dm_req) begin dm_req = 1; new_dm_op(0); end
      end
      default: begin
        if (if_req && seen_if) begin
          if ($urandom_range(0, 1) == 1) new_if_op(); else if_req = 0;
        end else if (!if_req && $urandom_range(0, 3) == 0) begin
          if_req = 1; new_if_op();
        end
        if (dm_req && seen_dm) begin
          if ($urandom_range(0, 1) == 1) new_dm_op(1); else dm_req = 0;
        end else if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1; new_dm_op(1);
        end
      end
    endcase
  endtask

  // one service starts whenever the port is free and someone is asking
  task automatic model_decide();
    bit take_d;
    int idx;
    if (cyc >= m_free && (if_req || dm_req)) begin
      take_d   = dm_req && !(if_req && m_streak == MAX_DSTREAK);
      m_streak = take_d ? ((m_streak < MAX_DSTREAK) ? m_streak + 1 : MAX_DSTREAK) : 0;
      e_dm     = take_d;
      e_we     = take_d && dm_we;
      e_rd     = !e_we;
      e_be     = take_d ? dm_be : 4'hF;
      e_addr   = take_d ? dm_addr : if_addr;
      e_wdata  = dm_wdata;
      idx      = int'(e_addr[7:2]);
      if (e_rd) begin
        e_rdata = ref_mem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (e_be[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
      end
      m_grant = cyc;
      e_issue = cyc + 1;
      e_valid = cyc + (e_rd ? MEM_LAT + 2 : 2);
      m_free  = e_valid + 1;
    end
  endtask

  task automatic check_outputs();
    bit iss, vn;
    iss = (cyc == e_issue);
    vn  = (cyc == e_valid);
    if (vn && e_rd) begin
      if (e_dm) exp_dm_rdata = e_rdata; else exp_if_rdata = e_rdata;
    end
    chk("mem_en", 64'(mem_en), 64'(iss));
    chk("mem_we", 64'(mem_we), 64'(iss && e_we));
    if (iss) begin
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_be", 64'(mem_be), 64'(e_be));
      if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    end
    chk("if_valid", 64'(if_valid), 64'(vn && !e_dm));
    chk("dm_valid", 64'(dm_valid), 64'(vn && e_dm));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
    chk("if_stall", 64'(if_stall), 64'(if_req && !(vn && !e_dm)));
    chk("dm_stall", 64'(dm_stall), 64'(dm_req && !(vn && e_dm)));
    chk("busy", 64'(busy), 64'(cyc > m_grant && cyc < m_free));
    seen_if = if_valid;
    seen_dm = dm_valid;
    if (if_valid) lv_if = cyc;
    if (dm_valid) lv_dm = cyc;
    if (log_en && (if_valid || dm_valid)) begin
      order = {order[4:0], dm_valid};
      n_log++;
    end
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tb_mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        rd_due = cyc + MEM_LAT;
        rd_idx = int'(mem_addr[7:2]);
      end
    end
  endtask

  task automatic tick();
    update_requesters();
    model_decide();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = (cyc == rd_due) ? tb_mem[rd_idx] : $urandom;
  endtask

  task automatic model_reset();
    m_free = cyc; m_grant = -100; m_streak = 0;
    e_issue = -100; e_valid = -100; rd_due = -100;
    exp_if_rdata = 0; exp_dm_rdata = 0;
    seen_if = 0; seen_dm = 0;
  endtask

  // main sequence
  initial begin
    int c0, r, n;
    logic [31:0] dm_before;
    reset = 0;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[4]  = 32'h0050_0093;
    ref_mem[4] = 32'h0050_0093;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valids", 64'({if_valid, dm_valid}), 0);
    chk("rst_rdata", 64'({if_rdata, dm_rdata}), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    reset = 1;
    cyc = 0;
    model_reset();
    mem_rdata = $urandom;

    // fetch only from address 0x10
    mode = 0;
    if_req = 1; if_addr = 32'h10;
    repeat (8) tick();
    chk("t1_if_valid_cycle", 64'(lv_if), 4);
    chk("t1_if_rdata", 64'(if_rdata), 64'h0050_0093);

    // simultaneous fetch and load: data first
    c0 = cyc;
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h80; dm_wdata = 0;
    repeat (12) tick();
    chk("t2_dm_valid_cycle", 64'(lv_dm - c0), 4);
    chk("t2_if_valid_cycle", 64'(lv_if - c0), 9);

    // partial store leaves load data untouched
    c0 = cyc;
    dm_before = dm_rdata;
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    repeat (5) tick();
    chk("t3_dm_valid_cycle", 64'(lv_dm - c0), 2);
    chk("t3_dm_rdata_kept", 64'(dm_rdata), 64'(dm_before));

    // randomized traffic
    mode = 2;
    repeat (3000) tick();

    // drain
    mode = 0;
    n = 0;
    while (!(!if_req && !dm_req && cyc >= m_free) && n < 400) begin tick(); n++; end
    if (n >= 400) chk("drain_timeout", 0, 1);
    tick();

    // reset while a fetch is in its latency wait
    if_req = 1; if_addr = 32'h10;
    tick(); tick();
    reset = 0;
    #1;
    chk("midrst_mem_en", 64'(mem_en), 0);
    chk("midrst_if_valid", 64'(if_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_if_rdata", 64'(if_rdata), 0);
    repeat (3) begin @(posedge clk); #1; cyc++; mem_rdata = $urandom; end
    reset = 1;
    r = cyc;
    model_reset();
    lv_if = -1;
    n = 0;
    while (lv_if < r && n < 20) begin tick(); n++; end
    chk("midrst_refetch_cycle", 64'(lv_if - r), 64'(MEM_LAT + 2));
    tick();

    // starvation guard: fetch held, loads re-requested back to back
    mode = 1;
    log_en = 1; order = 0; n_log = 0;
    n = 0;
    while (n_log < 6 && n < 200) begin tick(); n++; end
    log_en = 0;
    chk("starve_count", 64'(n_log), 6);
    chk("starve_order_DDDDFD", 64'(order), 64'(6'b111101));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // single load through the MEM_LAT=1 instance
  initial begin
    d1_if_req = 0; d1_if_addr = 0;
    d1_dm_req = 0; d1_dm_we = 0; d1_dm_be = 0; d1_dm_addr = 0; d1_dm_wdata = 0;
    d1_mem_rdata = 0;
    @(posedge reset);
    d1_dm_req = 1; d1_dm_be = 4'hF; d1_dm_addr = 32'h8;
    for (int k = 0; k < 6; k++) begin
      d1_mem_rdata = (k == 2) ? 32'hCAFE_F00D : $urandom;
      @(negedge clk);
      chk("lat1_mem_en", 64'(d1_mem_en), 64'(k == 1));
      chk("lat1_dm_valid", 64'(d1_dm_valid), 64'(k == 3));
      if (k == 3) chk("lat1_dm_rdata", 64'(d1_dm_rdata), 64'hCAFE_F00D);
      @(posedge clk);
      #1;
      if (k == 3) d1_dm_req = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipelined core's IF stage and its MEM stage.
- Sequences each access as grant, issue, fixed-latency wait, then response.
- Drives per-stage stall signals so the pipeline holds while its access is outstanding.
- Data-side priority, with a streak limit that keeps fetch from starving.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables = DATA_W/8).
- MEM_LAT, 2, cycles from ISSUE cycle to cycle mem_rdata is valid (>=1).
- MAX_DSTREAK, 4, consecutive data grants allowed while fetch waits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction (registered).
- if_valid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_valid.
- dm_req  in  1  data request; held with operands stable until dm_valid.
- dm_we  in  1  1=store, 0=load.
- dm_be  in  DATA_W/8  store byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data (registered).
- dm_valid  out  1  one-cycle data completion pulse.
- dm_stall  out  1  dm_req & ~dm_valid.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset value of every output and register is 0; state = IDLE; streak counter = 0. Assertion mid-transaction aborts it immediately: no valid pulse, mem_en drops at once. The requester keeps its request held and is re-serviced from IDLE after release.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests sampled only here. No request: stay in IDLE. Otherwise select a winner, register its command into mem_* at the cycle's end, go to ISSUE.
- Arbitration: dm wins over if. Exception: if_req pending and streak == MAX_DSTREAK, then fetch wins.
- Streak counter: data grant increments (saturating at MAX_DSTREAK); fetch grant clears it; idle cycles leave it unchanged.
- Fetch commands: mem_we=0, mem_be all ones.
- ISSUE: exactly one cycle with mem_en=1. Read goes to WAIT with counter = MEM_LAT; write goes to RESP.
- WAIT: counter decrements each cycle. In the cycle it reads 1 (the cycle MEM_LAT after ISSUE), mem_rdata is captured into if_rdata or dm_rdata for the owner, then go to RESP.
- RESP: owner's valid = 1 for exactly one cycle, then IDLE. A request still high during RESP is not re-serviced; IDLE next cycle resamples it.
- Latency, request first seen in cycle 0 with FSM idle:
  - read valid in cycle MEM_LAT+2;
  - write valid in cycle 2;
  - back-to-back service interval is read MEM_LAT+3, write 3.
- mem_en/mem_we are 0 outside ISSUE. mem_addr/mem_be/mem_wdata hold last issued values.
- if_rdata/dm_rdata hold until the next read completion for that requester; stores leave dm_rdata unchanged.
- Stalls are combinational from req and registered valid; no combinational path from mem_rdata to any output.

Test Plan:
- Fetch only: reset low cycles 0-2 then high; if_req=1, if_addr=0x10 at cycle 0; memory returns 0x00500093 in cycle 3 → mem_en=1 with mem_addr=0x10 in cycle 1; if_valid=1 with if_rdata=0x00500093 in cycle 4; if_stall=1 in cycles 0-3.
- Simultaneous fetch 0x20 and load 0x80 at cycle 0 → data ISSUE cycle 1, dm_valid cycle 4; fetch ISSUE cycle 6, if_valid cycle 9; dm_stall drops at cycle 4, if_stall at cycle 9.
- Store dm_we=1, dm_be=4'b0011, dm_addr=0x40, dm_wdata=0xDEADBEEF at cycle 0 → cycle 1 shows mem_en=1, mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; dm_valid cycle 2; dm_rdata unchanged.
- Starvation guard: if_req held while dm_req is reasserted immediately after each of 6 loads → grant order D,D,D,D,F,D; streak returns to 1 after the 6th grant.
- Reset mid-WAIT: assert reset in cycle 2 of a fetch → mem_en, if_valid, busy, if_rdata = 0 immediately; release at cycle 5 with if_req still held → fresh ISSUE 1 cycle after the first IDLE sample; if_valid exactly MEM_LAT+2 cycles after that sample.
- MEM_LAT=1 build: single load → dm_valid in cycle 3; mem_rdata captured from cycle 2.
